// File: rtl/clint_timer_n_pkg.sv
// Shared constants, address-decode result type and byte-merge helper for the
// clint_timer_n machine timer (optional MSIP block: CLINT_MSIP_EN).
package clint_timer_n_pkg;

   localparam logic [31:0] MTIME_ADDR    = 32'h0000_8004;
   localparam logic [31:0] MTIMECMP_ADDR = 32'h0000_800C;

   localparam int CLINT_MTIME_LO_OFS = 0;
   localparam int CLINT_MTIME_HI_OFS = 4;
   localparam int CLINT_MTIMECMP_OFS = 8;
   localparam int CLINT_HART_STRIDE  = 8;

   localparam logic [63:0] CLINT_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      DEC_MTIME_LO,
      DEC_MTIME_HI,
      DEC_CMP_LO,
      DEC_CMP_HI,
      DEC_MSIP,
      DEC_ERR
   } clint_dec_e;

   function automatic logic [31:0] clint_merge_be(input logic [31:0] old_val,
                                                  input logic [31:0] new_val,
                                                  input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 and emits a tick on the wrap cycle.
// A restart forces the count back to 0 and suppresses that cycle's tick.
module clint_prescaler #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_restart,
   output logic o_tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] r_count;

   assign o_tick = (r_count == PW'(TICK_DIV - 1)) && !i_restart;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_restart || o_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + PW'(1);
      end
   end

endmodule

// File: rtl/clint_timer_n.sv
// Memory-mapped machine timer: shared prescaled 64-bit mtime, per-hart mtimecmp
// and registered mtip. Define CLINT_MSIP_EN to add per-hart msip registers.
module clint_timer_n
   import clint_timer_n_pkg::*;
#(
   parameter int          NUM_HARTS = 1,
   parameter logic [31:0] BASE_ADDR = MTIME_ADDR,
   parameter int          TICK_DIV  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [31:0]          addr_i,
   input  logic [31:0]          wdata_i,
   input  logic [3:0]           be_i,
   output logic                 ack_o,
   output logic                 err_o,
   output logic [31:0]          rdata_o,
   output logic [63:0]          mtime_o,
`ifdef CLINT_MSIP_EN
   output logic [NUM_HARTS-1:0] msip_o,
`endif
   output logic [NUM_HARTS-1:0] mtip_o
);

   localparam int          HW       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
   localparam logic [31:0] CMP_END  = 32'(CLINT_MTIMECMP_OFS + CLINT_HART_STRIDE * NUM_HARTS);
   localparam logic [31:0] MSIP_END = CMP_END + 32'(4 * NUM_HARTS);

   logic [63:0]          r_mtime;
   logic [63:0]          r_cmp [NUM_HARTS];
   logic [31:0]          r_shadow;
   logic                 r_ack;
   logic                 r_err;
   logic [31:0]          r_rdata;
   logic [NUM_HARTS-1:0] r_mtip;

   logic [31:0] w_ofs;
   clint_dec_e  w_dec;
   logic [HW-1:0] w_hart;
   logic [31:0] w_rdata;
   logic        w_wr;
   logic        w_rd;
   logic        w_mtime_wr;
   logic        w_tick;

   assign w_ofs      = addr_i - BASE_ADDR;
   assign w_wr       = req_i && we_i;
   assign w_rd       = req_i && !we_i;
   assign w_mtime_wr = w_wr && ((w_dec == DEC_MTIME_LO) || (w_dec == DEC_MTIME_HI));

   // Addresses below BASE_ADDR wrap to huge offsets and fall through to DEC_ERR.
   always_comb begin
      w_dec  = DEC_ERR;
      w_hart = '0;
      if (addr_i[1:0] != 2'b00) begin
         w_dec = DEC_ERR;
      end else if (w_ofs == 32'(CLINT_MTIME_LO_OFS)) begin
         w_dec = DEC_MTIME_LO;
      end else if (w_ofs == 32'(CLINT_MTIME_HI_OFS)) begin
         w_dec = DEC_MTIME_HI;
      end else if ((w_ofs >= 32'(CLINT_MTIMECMP_OFS)) && (w_ofs < CMP_END)) begin
         w_hart = HW'((w_ofs - 32'(CLINT_MTIMECMP_OFS)) / 32'(CLINT_HART_STRIDE));
         w_dec  = w_ofs[2] ? DEC_CMP_HI : DEC_CMP_LO;
`ifdef CLINT_MSIP_EN
      end else if ((w_ofs >= CMP_END) && (w_ofs < MSIP_END)) begin
         w_hart = HW'((w_ofs - CMP_END) >> 2);
         w_dec  = DEC_MSIP;
`endif
      end
   end

   clint_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_restart (w_mtime_wr),
      .o_tick    (w_tick)
   );

`ifdef CLINT_MSIP_EN
   logic [NUM_HARTS-1:0] r_msip;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_msip <= '0;
      end else if (w_wr && (w_dec == DEC_MSIP) && be_i[0]) begin
         r_msip[w_hart] <= wdata_i[0];
      end
   end

   assign msip_o = r_msip;
`endif

   always_comb begin
      w_rdata = '0;
      case (w_dec)
         DEC_MTIME_LO: w_rdata = r_mtime[31:0];
         DEC_MTIME_HI: w_rdata = r_shadow;
         DEC_CMP_LO:   w_rdata = r_cmp[w_hart][31:0];
         DEC_CMP_HI:   w_rdata = r_cmp[w_hart][63:32];
`ifdef CLINT_MSIP_EN
         DEC_MSIP:     w_rdata = {31'd0, r_msip[w_hart]};
`endif
         default:      w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mtime  <= '0;
         r_shadow <= '0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
         r_mtip   <= '0;
         for (int h = 0; h < NUM_HARTS; h++) begin
            r_cmp[h] <= CLINT_MTIMECMP_RESET;
         end
      end else begin
         r_ack   <= req_i;
         r_err   <= req_i && (w_dec == DEC_ERR);
         r_rdata <= w_rd ? w_rdata : '0;
         if (w_rd && (w_dec == DEC_MTIME_LO)) begin
            r_shadow <= r_mtime[63:32];
         end
         // A software write to mtime takes precedence over the tick of the same cycle.
         if (w_wr && (w_dec == DEC_MTIME_LO)) begin
            r_mtime[31:0] <= clint_merge_be(r_mtime[31:0], wdata_i, be_i);
         end else if (w_wr && (w_dec == DEC_MTIME_HI)) begin
            r_mtime[63:32] <= clint_merge_be(r_mtime[63:32], wdata_i, be_i);
         end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
         end
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_wr && (w_hart == HW'(h)) && (w_dec == DEC_CMP_LO)) begin
               r_cmp[h][31:0] <= clint_merge_be(r_cmp[h][31:0], wdata_i, be_i);
            end else if (w_wr && (w_hart == HW'(h)) && (w_dec == DEC_CMP_HI)) begin
               r_cmp[h][63:32] <= clint_merge_be(r_cmp[h][63:32], wdata_i, be_i);
            end
            r_mtip[h] <= (r_mtime >= r_cmp[h]);
         end
      end
   end

   assign ack_o   = r_ack;
   assign err_o   = r_err;
   assign rdata_o = r_rdata;
   assign mtime_o = r_mtime;
   assign mtip_o  = r_mtip;

endmodule

// File: tb/tb_clint_timer_n.sv
// Self-checking bench for clint_timer_n (NUM_HARTS=2, TICK_DIV=4, CLINT_MSIP_EN undefined).
// mtime is modelled as base + floor(edges since last write / TICK_DIV).
module tb_clint_timer_n;

   localparam int          NH   = 2;
   localparam int          D    = 4;
   localparam logic [31:0] BASE = 32'h0000_8004;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_i = 1'b0;
   logic          we_i = 1'b0;
   logic [31:0]   addr_i = '0;
   logic [31:0]   wdata_i = '0;
   logic [3:0]    be_i = '0;
   logic          ack_o;
   logic          err_o;
   logic [31:0]   rdata_o;
   logic [63:0]   mtime_o;
   logic [NH-1:0] mtip_o;

   clint_timer_n #(
      .NUM_HARTS (NH),
      .BASE_ADDR (BASE),
      .TICK_DIV  (D)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (req_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .be_i    (be_i),
      .ack_o   (ack_o),
      .err_o   (err_o),
      .rdata_o (rdata_o),
      .mtime_o (mtime_o),
      .mtip_o  (mtip_o)
   );

   always #5 clk = ~clk;

   longint unsigned edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Reference model state
   logic [63:0]     m_base;
   longint unsigned m_base_edge;
   logic [63:0]     m_cmp [NH];
   logic [31:0]     m_shadow;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [63:0] m_at(input longint unsigned n);
      return m_base + 64'((n - m_base_edge) / longint'(D));
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_base      = '0;
      m_base_edge = edge_cnt;
      m_shadow    = '0;
      for (int h = 0; h < NH; h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
   endtask

   // Starts and ends on a falling edge; one bus transaction per call.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input string tag);
      logic [63:0] pre;
      logic [31:0] ofs;
      logic [31:0] exp_rd;
      int          kind;
      int          h;
      longint unsigned e;
      pre  = m_at(edge_cnt);
      e    = edge_cnt + 1;
      ofs  = addr - BASE;
      kind = 4;
      h    = 0;
      if (addr[1:0] == 2'b00) begin
         if (ofs == 0) kind = 0;
         else if (ofs == 4) kind = 1;
         else if (ofs >= 8 && ofs < 32'(8 + 8*NH)) begin
            h    = int'((ofs - 8) / 8);
            kind = (((ofs - 8) % 8) == 4) ? 3 : 2;
         end
      end
      case (kind)
         0:       exp_rd = pre[31:0];
         1:       exp_rd = m_shadow;
         2:       exp_rd = m_cmp[h][31:0];
         3:       exp_rd = m_cmp[h][63:32];
         default: exp_rd = '0;
      endcase
      req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
      @(posedge clk);
      if (we) begin
         case (kind)
            0: begin m_base = {pre[63:32], merge(pre[31:0], wd, be)}; m_base_edge = e; end
            1: begin m_base = {merge(pre[63:32], wd, be), pre[31:0]}; m_base_edge = e; end
            2: m_cmp[h][31:0]  = merge(m_cmp[h][31:0], wd, be);
            3: m_cmp[h][63:32] = merge(m_cmp[h][63:32], wd, be);
            default: ;
         endcase
      end else if (kind == 0) begin
         m_shadow = pre[63:32];
      end
      @(negedge clk);
      req_i = 1'b0; we_i = 1'b0;
      check({tag, "_ack"}, 64'(ack_o), 64'd1);
      check({tag, "_err"}, 64'(err_o), 64'(kind == 4));
      if (!we) check({tag, "_rdata"}, 64'(rdata_o), 64'(exp_rd));
      check({tag, "_mtime"}, mtime_o, m_at(edge_cnt));
      $display("txn %s we=%0d addr=%h wdata=%h be=%h -> ack=%0d err=%0d rdata=%h mtime=%h",
               tag, we, addr, wd, be, ack_o, err_o, rdata_o, mtime_o);
   endtask

   task automatic idle(input int n);
      logic [NH-1:0] exp_tip;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         for (int h = 0; h < NH; h++) exp_tip[h] = (m_at(edge_cnt - 1) >= m_cmp[h]);
         check("idle_mtime", mtime_o, m_at(edge_cnt));
         check("idle_mtip", 64'(mtip_o), 64'(exp_tip));
         check("idle_ack", 64'(ack_o), 64'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] tgt;
      int          hh;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_mtime", mtime_o, 64'd0);
      check("rst_mtip", 64'(mtip_o), 64'd0);
      check("rst_ack", 64'(ack_o), 64'd0);
      check("rst_err", 64'(err_o), 64'd0);
      check("rst_rdata", 64'(rdata_o), 64'd0);
      rst_n = 1'b1;
      model_reset();

      // Free run from reset, then shadow and compare defaults
      idle(10);
      access(1'b0, BASE + 32'd4, '0, '0, "rd_hi_noshadow");
      access(1'b0, BASE, '0, '0, "rd_lo_free");
      access(1'b0, BASE + 32'd8, '0, '0, "rd_cmp0_lo");
      access(1'b0, BASE + 32'd20, '0, '0, "rd_cmp1_hi");
      check("cmp1_hi_reset", 64'(rdata_o), 64'hFFFF_FFFF);

      // 40 cycles at TICK_DIV=4 gives 10 ticks
      access(1'b1, BASE + 32'd4, 32'd0, 4'hF, "wr_hi0");
      access(1'b1, BASE, 32'd0, 4'hF, "wr_lo0");
      idle(40);
      access(1'b0, BASE, '0, '0, "rd_lo_40");
      check("mtime_after_40", 64'(rdata_o), 64'd10);

      // Carry across the 32-bit boundary with tear-free lo/hi read
      access(1'b1, BASE + 32'd4, 32'd0, 4'hF, "wr_hi_c");
      access(1'b1, BASE, 32'hFFFF_FFFE, 4'hF, "wr_lo_c");
      idle(12);
      access(1'b0, BASE, '0, '0, "rd_lo_c");
      access(1'b0, BASE + 32'd4, '0, '0, "rd_hi_c");
      check("carry_hi", 64'(rdata_o), 64'd1);

      // Hart 1 compare at 100 starting from mtime 90
      access(1'b1, BASE, 32'd90, 4'hF, "wr_lo90");
      access(1'b1, BASE + 32'd4, 32'd0, 4'hF, "wr_hi90");
      access(1'b1, BASE + 32'd20, 32'd0, 4'hF, "wr_cmp1_hi");
      access(1'b1, BASE + 32'd16, 32'd100, 4'hF, "wr_cmp1_lo");
      idle(50);
      check("mtip_hart1", 64'(mtip_o), 64'b10);
      access(1'b1, BASE + 32'd16, 32'hFFFF_FFFF, 4'hF, "wr_cmp1_lo_ff");
      idle(1);
      check("mtip_clear", 64'(mtip_o), 64'd0);
      access(1'b1, BASE + 32'd20, 32'hFFFF_FFFF, 4'hF, "wr_cmp1_hi_ff");
      idle(2);

      // Error responses leave state untouched
      access(1'b0, BASE + 32'd2, '0, '0, "rd_misalign");
      access(1'b0, BASE + 32'd24, '0, '0, "rd_msip_unmapped");
      access(1'b1, BASE + 32'd24, 32'h1, 4'hF, "wr_msip_unmapped");
      access(1'b1, BASE + 32'd9, 32'h0, 4'hF, "wr_misalign");
      access(1'b0, BASE - 32'd4, '0, '0, "rd_below");
      idle(4);

      // Write mtime_lo exactly on a tick edge: no increment that cycle
      for (int k = 0; k < 2*D && (((edge_cnt + 1 - m_base_edge) % longint'(D)) != 0); k++) idle(1);
      check("tick_aligned", 64'((edge_cnt + 1 - m_base_edge) % longint'(D)), 64'd0);
      access(1'b1, BASE, 32'h0000_1234, 4'hF, "wr_on_tick");
      idle(3);
      check("tick_dropped", 64'(mtime_o[31:0]), 64'h0000_1234);

      // Randomized traffic
      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 5))
            0: idle(int'($urandom_range(1, 6)));
            1: access(1'b0, BASE + 32'(4 * $urandom_range(0, 5)), '0, '0, "rnd_rd");
            2: begin
               hh  = int'($urandom_range(0, NH - 1));
               tgt = m_at(edge_cnt) + 64'($urandom_range(0, 24));
               access(1'b1, BASE + 32'(12 + 8*hh), tgt[63:32], 4'hF, "rnd_cmp_hi");
               access(1'b1, BASE + 32'(8 + 8*hh), tgt[31:0], 4'hF, "rnd_cmp_lo");
               idle(int'($urandom_range(4, 30)));
            end
            3: access(1'b1, BASE + 32'(4 * $urandom_range(0, 5)), $urandom,
                      4'($urandom_range(0, 15)), "rnd_wr");
            4: access(1'($urandom_range(0, 1)), BASE + 32'(24 + $urandom_range(0, 15)),
                      $urandom, 4'hF, "rnd_err");
            default: begin
               access(1'b0, BASE, '0, '0, "rnd_pair_lo");
               idle(int'($urandom_range(0, 3)));
               access(1'b0, BASE + 32'd4, '0, '0, "rnd_pair_hi");
            end
         endcase
      end
      idle(3);

      // Asynchronous reset mid-count drops the pending ack
      idle(7);
      req_i = 1'b1; we_i = 1'b0; addr_i = BASE;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req_i = 1'b0;
      #1;
      check("midrst_ack", 64'(ack_o), 64'd0);
      check("midrst_mtime", mtime_o, 64'd0);
      check("midrst_mtip", 64'(mtip_o), 64'd0);
      check("midrst_rdata", 64'(rdata_o), 64'd0);
      $display("txn mid_reset ack=%0d mtime=%h", ack_o, mtime_o);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      access(1'b0, BASE + 32'd4, '0, '0, "post_rst_hi");
      access(1'b0, BASE + 32'd8, '0, '0, "post_rst_cmp0_lo");
      check("post_rst_cmp0", 64'(rdata_o), 64'hFFFF_FFFF);
      access(1'b0, BASE + 32'd20, '0, '0, "post_rst_cmp1_hi");
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
